// File: rtl/fp_divide.sv
// Iterative IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even in NORM; otherwise the quotient is truncated.
module fp_divide #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      div_start,
  input  logic [EXP_W+FRAC_W:0]     op1,
  input  logic [EXP_W+FRAC_W:0]     op2,
  output logic [EXP_W+FRAC_W:0]     div_result,
  output logic                      div_done,
  output logic                      div_overflow,
  output logic                      div_busy
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int QW  = FRAC_W + 3;
  localparam int RW  = FRAC_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam int CW  = $clog2(QW + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] DIVIDE = 3'd2;
  localparam logic [2:0] NORM   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;
  localparam logic signed [EW2-1:0] E_BIAS = EW2'(BIAS);

  logic [2:0]        state;
  logic [W-1:0]      a, b;
  logic [QW-1:0]     q;
  logic [RW-1:0]     rem;
  logic [FRAC_W:0]   dv;
  logic [CW-1:0]     cnt;

  logic              sign;
  logic              e1_zero, e1_ones, e2_zero, e2_ones;
  logic              ge;
  logic [RW-1:0]     rem_sel;
  logic              q_msb;
  logic [FRAC_W-1:0] frac_n;
  logic signed [EW2-1:0] e_n;
  logic [W-1:0]      norm_res;
  logic              norm_ovf;
`ifdef FP_DIV_ROUND_EN
  logic              guard, sticky;
  logic [FRAC_W:0]   frac_inc;
`endif

  assign sign    = a[W-1] ^ b[W-1];
  assign e1_zero = (a[W-2:FRAC_W] == '0);
  assign e1_ones = (a[W-2:FRAC_W] == '1);
  assign e2_zero = (b[W-2:FRAC_W] == '0);
  assign e2_ones = (b[W-2:FRAC_W] == '1);

  assign div_done = (state == DONE);
  assign div_busy = (state != IDLE);

  always_comb begin
    ge      = (rem >= {1'b0, dv});
    rem_sel = ge ? (rem - {1'b0, dv}) : rem;
  end

  always_comb begin
    q_msb  = q[QW-1];
    frac_n = q_msb ? q[FRAC_W+1:2] : q[FRAC_W:1];
    e_n    = $signed({2'b00, a[W-2:FRAC_W]}) - $signed({2'b00, b[W-2:FRAC_W]}) + E_BIAS
             - $signed({{(EW2-1){1'b0}}, ~q_msb});
`ifdef FP_DIV_ROUND_EN
    // Guard is the first dropped quotient bit; remaining bits plus the remainder form sticky.
    guard    = q_msb ? q[1] : q[0];
    sticky   = (q_msb & q[0]) | (rem != '0);
    frac_inc = {1'b0, frac_n} + 1'b1;
    if (guard && (sticky || frac_n[0])) begin
      frac_n = frac_inc[FRAC_W-1:0];
      if (frac_inc[FRAC_W])
        e_n = e_n + 1'sb1;
    end
`endif
    norm_res = {sign, e_n[EXP_W-1:0], frac_n};
    norm_ovf = 1'b0;
    if (e_n >= E_MAX) begin
      norm_res = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      norm_ovf = 1'b1;
    end else if (e_n <= E_ZERO) begin
      norm_res = {sign, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      div_result   <= '0;
      div_overflow <= 1'b0;
      a            <= '0;
      b            <= '0;
      q            <= '0;
      rem          <= '0;
      dv           <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            a     <= op1;
            b     <= op2;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (e1_ones || e2_ones || (e1_zero && e2_zero)) begin
            div_result   <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            div_overflow <= 1'b1;
            state        <= DONE;
          end else if (e2_zero) begin
            div_result   <= {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            div_overflow <= 1'b1;
            state        <= DONE;
          end else if (e1_zero) begin
            div_result   <= {sign, {(W-1){1'b0}}};
            div_overflow <= 1'b0;
            state        <= DONE;
          end else begin
            rem   <= {2'b01, a[FRAC_W-1:0]};
            dv    <= {1'b1, b[FRAC_W-1:0]};
            q     <= '0;
            cnt   <= CW'(QW);
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          q   <= {q[QW-2:0], ge};
          rem <= rem_sel << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= NORM;
        end
        NORM: begin
          div_result   <= norm_res;
          div_overflow <= norm_ovf;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divide.sv
// Scoreboard bench for fp_divide: directed vectors push expectations, a monitor pops on div_done.
module tb_fp_divide;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] div_result;
  logic        div_done;
  logic        div_overflow;
  logic        div_busy;

  fp_divide #(.EXP_W(8), .FRAC_W(23), .BIAS(127)) dut (
    .clk(clk), .n_rst(n_rst), .div_start(div_start), .op1(op1), .op2(op2),
    .div_result(div_result), .div_done(div_done), .div_overflow(div_overflow),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int unsigned lat;
    int unsigned acc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst && prev_done)
      check("done_pulse_width", {31'd0, div_done}, 32'd0);
    if (n_rst && div_done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_result"}, div_result, e.res);
        check({e.name, "_ovf"}, {31'd0, div_overflow}, {31'd0, e.ovf});
        check({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
    prev_done = n_rst && div_done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!div_busy) return;
    end
    check("idle_timeout", {31'd0, div_busy}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic ovf, input int unsigned lat, input string name);
    exp_t e;
    wait_idle();
    op1 = a;
    op2 = b;
    div_start = 1'b1;
    e.res = res; e.ovf = ovf; e.lat = lat; e.acc = cyc + 1; e.name = name;
    sbq.push_back(e);
    @(negedge clk);
    div_start = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_result", div_result, 32'h0);
    check("rst_done", {31'd0, div_done}, 32'd0);
    check("rst_ovf", {31'd0, div_overflow}, 32'd0);
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    issue(32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 28, "six_by_three");
    issue(32'h3FF00000, 32'h3FC00000, 32'h3FA00000, 1'b0, 28, "1p875_by_1p5");
    issue(32'hC0C00000, 32'h40400000, 32'hC0000000, 1'b0, 28, "neg_six_by_three");
`ifdef FP_DIV_ROUND_EN
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, "one_by_three");
`else
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28, "one_by_three");
`endif
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1, "div_by_zero");
    issue(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1, "zero_by_zero");
    issue(32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1, "inf_operand");
    issue(32'h00000000, 32'hC0400000, 32'h80000000, 1'b0, 1, "zero_dividend");
    issue(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 28, "exp_overflow");
    issue(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 28, "exp_underflow");

    // Start pulsed while busy must not disturb the in-flight result or add a done.
    issue(32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 28, "busy_first");
    repeat (3) @(negedge clk);
    op1 = 32'h3F800000;
    op2 = 32'h00000000;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    op1 = '0;
    op2 = '0;

    // Reset in the middle of DIVIDE aborts without a done pulse.
    issue(32'h3FF00000, 32'h3FC00000, 32'h3FA00000, 1'b0, 28, "aborted");
    repeat (10) @(negedge clk);
    n_rst = 1'b0;
    void'(sbq.pop_back());
    #1;
    check("mid_rst_result", div_result, 32'h0);
    check("mid_rst_done", {31'd0, div_done}, 32'd0);
    check("mid_rst_ovf", {31'd0, div_overflow}, 32'd0);
    check("mid_rst_busy", {31'd0, div_busy}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    issue(32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 28, "after_reset");

    for (int i = 0; i < 200 && sbq.size() != 0; i++)
      @(negedge clk);
    check("queue_drained", sbq.size(), 32'd0);
    repeat (3) @(negedge clk);
    check("result_held", div_result, 32'h40000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
